// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader and run supervisor.
// Accepts a length-prefixed, XOR-checksummed byte stream, writes it into
// program memory, releases the processor from reset and watches the run
// until the processor halts or the watchdog expires.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; waiting for start_i
// LEN     | waiting for the length byte
// DATA    | accepting program bytes, one memory write per byte
// CSUM    | waiting for the checksum byte
// RELEASE | holding processor reset for RST_CYCLES cycles
// RUN     | processor running; run cycles counted, watchdog armed
// HALTED  | processor halted; done_o asserted
// ERROR   | bad length, checksum mismatch or timeout; err_o asserted
module prog_loader #(
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 8,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1000,
    parameter int CWIDTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DWIDTH-1:0] load_data_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_own_o,
    output logic              cpu_rst_o,
    input  logic              cpu_halt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [CWIDTH-1:0] run_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_RELEASE, S_RUN, S_HALTED, S_ERROR
    } state_t;

    localparam int RWIDTH = $clog2(RST_CYCLES + 1);
    localparam logic [DWIDTH:0] MAX_LEN = (DWIDTH+1)'(2**AWIDTH);

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [AWIDTH:0]     count_q, count_d;
    logic [DWIDTH-1:0]   csum_q, csum_d;
    logic [RWIDTH-1:0]   rel_q, rel_d;
    logic [CWIDTH-1:0]   run_q, run_d;
    logic [1:0]          code_q, code_d;
    logic                we_q, we_d;
    logic [AWIDTH-1:0]   waddr_q, waddr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                accept;

    assign load_ready_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept       = load_valid_i && load_ready_o;
    assign busy_o       = load_ready_o || (state_q == S_RELEASE);
    assign done_o       = (state_q == S_HALTED);
    assign err_o        = (state_q == S_ERROR);
    // Processor owns memory and runs only in RUN and HALTED.
    assign cpu_rst_o    = !((state_q == S_RUN) || (state_q == S_HALTED));
    assign mem_own_o    = cpu_rst_o;
    assign err_code_o   = code_q;
    assign run_cycles_o = run_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = waddr_q;
    assign mem_wdata_o  = wdata_q;

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            csum_q  <= '0;
            rel_q   <= '0;
            run_q   <= '0;
            code_q  <= 2'b00;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            rel_q   <= rel_d;
            run_q   <= run_d;
            code_q  <= code_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, stream handling, release timer and watchdog.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        csum_d  = csum_q;
        rel_d   = rel_q;
        run_d   = run_q;
        code_d  = code_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    run_d   = '0;
                    code_d  = 2'b00;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if ((load_data_i == '0) || ({1'b0, load_data_i} > MAX_LEN)) begin
                        state_d = S_ERROR;
                        code_d  = 2'b01;
                    end else begin
                        count_d = load_data_i[AWIDTH:0];
                        addr_d  = '0;
                        csum_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = load_data_i;
                    addr_d  = addr_q + 1'b1;
                    csum_d  = csum_q ^ load_data_i;
                    count_d = count_q - 1'b1;
                    if (count_q == (AWIDTH+1)'(1)) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (load_data_i == csum_q) begin
                        state_d = S_RELEASE;
                        rel_d   = RWIDTH'(RST_CYCLES - 1);
                    end else begin
                        state_d = S_ERROR;
                        code_d  = 2'b10;
                    end
                end
            end
            S_RELEASE: begin
                if (rel_q == '0) state_d = S_RUN;
                else             rel_d   = rel_q - 1'b1;
            end
            S_RUN: begin
                // Halt takes priority over a coincident timeout.
                if (cpu_halt_i) begin
                    state_d = S_HALTED;
                end else begin
                    run_d = run_q + 1'b1;
                    if (run_d == CWIDTH'(TIMEOUT)) begin
                        state_d = S_ERROR;
                        code_d  = 2'b11;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
